// File: rtl/i2c_arbiter.sv
// Two-port round-robin sequencer that shares one i2c_dri master between two requesters.
// Each port command is captured, issued as a single i2c_exec pulse and completed back to its owner.
module i2c_arbiter #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_exec,
  input  logic        req0_rh_wl,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_data_w,
  input  logic        req0_bit_ctrl,
  output logic        req0_busy,
  output logic        req0_done,
  output logic        req0_ack,
  output logic        req0_timeout,
  output logic [7:0]  req0_data_r,
  input  logic        req1_exec,
  input  logic        req1_rh_wl,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_data_w,
  input  logic        req1_bit_ctrl,
  output logic        req1_busy,
  output logic        req1_done,
  output logic        req1_ack,
  output logic        req1_timeout,
  output logic [7:0]  req1_data_r,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  output logic        bit_ctrl,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  input  logic [7:0]  i2c_data_r
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 16'd1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  logic [1:0]  exec_v, rhwl_v, bitc_v;
  logic [15:0] addr_v  [2];
  logic [7:0]  dataw_v [2];

  assign exec_v     = {req1_exec, req0_exec};
  assign rhwl_v     = {req1_rh_wl, req0_rh_wl};
  assign bitc_v     = {req1_bit_ctrl, req0_bit_ctrl};
  assign addr_v[0]  = req0_addr;
  assign addr_v[1]  = req1_addr;
  assign dataw_v[0] = req0_data_w;
  assign dataw_v[1] = req1_data_w;

  state_t      state_q, state_d;
  logic [1:0]  pending_q;
  logic [1:0]  clear_v;
  logic [1:0]  hold_rhwl_q, hold_bitc_q;
  logic [15:0] hold_addr_q  [2];
  logic [7:0]  hold_dataw_q [2];
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        exec_q, exec_d;
  logic        m_rhwl_q, m_rhwl_d;
  logic [15:0] m_addr_q, m_addr_d;
  logic [7:0]  m_dataw_q, m_dataw_d;
  logic        m_bitc_q, m_bitc_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  to_q, to_d;
  logic [7:0]  datar_q [2];
  logic [7:0]  datar_d [2];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    exec_d    = 1'b0;
    m_rhwl_d  = m_rhwl_q;
    m_addr_d  = m_addr_q;
    m_dataw_d = m_dataw_q;
    m_bitc_d  = m_bitc_q;
    done_d    = 2'b00;
    ack_d     = ack_q;
    to_d      = to_q;
    datar_d   = datar_q;
    clear_v   = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          // Prefer the port that did not finish last; fall back to whichever is pending.
          grant_d   = pending_q[~last_q] ? ~last_q : last_q;
          m_rhwl_d  = hold_rhwl_q[grant_d];
          m_addr_d  = hold_addr_q[grant_d];
          m_dataw_d = hold_dataw_q[grant_d];
          m_bitc_d  = hold_bitc_q[grant_d];
          exec_d    = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i2c_done) begin
          done_d[grant_q]  = 1'b1;
          ack_d[grant_q]   = i2c_ack;
          to_d[grant_q]    = 1'b0;
          if (m_rhwl_q) datar_d[grant_q] = i2c_data_r;
          clear_v[grant_q] = 1'b1;
          last_d           = grant_q;
          state_d          = S_IDLE;
        end else if (cnt_q == TERM) begin
          done_d[grant_q]  = 1'b1;
          ack_d[grant_q]   = 1'b1;
          to_d[grant_q]    = 1'b1;
          clear_v[grant_q] = 1'b1;
          last_d           = grant_q;
          cnt_d            = '0;
          state_d          = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // The master may still be mid-transfer; hold off new issues until it settles.
        if (i2c_done || cnt_q == TERM) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= 2'b00;
      hold_rhwl_q <= 2'b00;
      hold_bitc_q <= 2'b00;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      exec_q      <= 1'b0;
      m_rhwl_q    <= 1'b0;
      m_addr_q    <= 16'h0000;
      m_dataw_q   <= 8'h00;
      m_bitc_q    <= 1'b0;
      done_q      <= 2'b00;
      ack_q       <= 2'b00;
      to_q        <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        hold_addr_q[i]  <= 16'h0000;
        hold_dataw_q[i] <= 8'h00;
        datar_q[i]      <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      exec_q    <= exec_d;
      m_rhwl_q  <= m_rhwl_d;
      m_addr_q  <= m_addr_d;
      m_dataw_q <= m_dataw_d;
      m_bitc_q  <= m_bitc_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      to_q      <= to_d;
      datar_q   <= datar_d;
      for (int i = 0; i < 2; i++) begin
        if (exec_v[i] && !pending_q[i]) begin
          pending_q[i]    <= 1'b1;
          hold_rhwl_q[i]  <= rhwl_v[i];
          hold_bitc_q[i]  <= bitc_v[i];
          hold_addr_q[i]  <= addr_v[i];
          hold_dataw_q[i] <= dataw_v[i];
        end else if (clear_v[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  assign req0_busy    = pending_q[0];
  assign req1_busy    = pending_q[1];
  assign req0_done    = done_q[0];
  assign req1_done    = done_q[1];
  assign req0_ack     = ack_q[0];
  assign req1_ack     = ack_q[1];
  assign req0_timeout = to_q[0];
  assign req1_timeout = to_q[1];
  assign req0_data_r  = datar_q[0];
  assign req1_data_r  = datar_q[1];
  assign i2c_exec     = exec_q;
  assign i2c_rh_wl    = m_rhwl_q;
  assign i2c_addr     = m_addr_q;
  assign i2c_data_w   = m_dataw_q;
  assign bit_ctrl     = m_bitc_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: the bench plays the i2c_dri master and checks
// issue order, latency, completions, timeout/drain handling and reset behaviour.
module tb_i2c_arbiter;
  logic        clk;
  logic        rst_n;
  logic        req0_exec, req0_rh_wl, req0_bit_ctrl;
  logic [15:0] req0_addr;
  logic [7:0]  req0_data_w;
  logic        req0_busy, req0_done, req0_ack, req0_timeout;
  logic [7:0]  req0_data_r;
  logic        req1_exec, req1_rh_wl, req1_bit_ctrl;
  logic [15:0] req1_addr;
  logic [7:0]  req1_data_w;
  logic        req1_busy, req1_done, req1_ack, req1_timeout;
  logic [7:0]  req1_data_r;
  logic        i2c_exec, i2c_rh_wl, bit_ctrl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic        i2c_done, i2c_ack;
  logic [7:0]  i2c_data_r;

  int n_cmp  = 0;
  int n_fail = 0;
  int exec_total = 0;
  int base;
  bit flag;

  i2c_arbiter #(.TIMEOUT_CYC(16'd64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_exec(req0_exec), .req0_rh_wl(req0_rh_wl), .req0_addr(req0_addr),
    .req0_data_w(req0_data_w), .req0_bit_ctrl(req0_bit_ctrl),
    .req0_busy(req0_busy), .req0_done(req0_done), .req0_ack(req0_ack),
    .req0_timeout(req0_timeout), .req0_data_r(req0_data_r),
    .req1_exec(req1_exec), .req1_rh_wl(req1_rh_wl), .req1_addr(req1_addr),
    .req1_data_w(req1_data_w), .req1_bit_ctrl(req1_bit_ctrl),
    .req1_busy(req1_busy), .req1_done(req1_done), .req1_ack(req1_ack),
    .req1_timeout(req1_timeout), .req1_data_r(req1_data_r),
    .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr),
    .i2c_data_w(i2c_data_w), .bit_ctrl(bit_ctrl),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack), .i2c_data_r(i2c_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (i2c_exec === 1'b1) exec_total <= exec_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit port, input logic rh, input logic [15:0] a,
                       input logic [7:0] dw, input logic bc);
    if (port == 1'b0) begin
      req0_rh_wl = rh; req0_addr = a; req0_data_w = dw; req0_bit_ctrl = bc; req0_exec = 1'b1;
    end else begin
      req1_rh_wl = rh; req1_addr = a; req1_data_w = dw; req1_bit_ctrl = bc; req1_exec = 1'b1;
    end
    $display("tb: port%0d exec rh_wl=%0b addr=%h data_w=%h", port, rh, a, dw);
    tick();
    req0_exec = 1'b0;
    req1_exec = 1'b0;
  endtask

  task automatic dri_done(input logic ack, input logic [7:0] d);
    i2c_done = 1'b1; i2c_ack = ack; i2c_data_r = d;
    tick();
    i2c_done = 1'b0;
    $display("tb: i2c_done ack=%0b data_r=%h", ack, d);
  endtask

  task automatic wait_exec(input logic [15:0] a, input string tag);
    int n = 0;
    while (i2c_exec !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_exec_seen"}, {31'd0, i2c_exec}, 32'd1);
    check({tag, "_addr"}, {16'd0, i2c_addr}, {16'd0, a});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_exec = 0; req0_rh_wl = 0; req0_addr = 0; req0_data_w = 0; req0_bit_ctrl = 0;
    req1_exec = 0; req1_rh_wl = 0; req1_addr = 0; req1_data_w = 0; req1_bit_ctrl = 0;
    i2c_done = 0; i2c_ack = 0; i2c_data_r = 0;
    tick(); tick(); tick();
    check("rst_exec", {31'd0, i2c_exec}, 32'd0);
    check("rst_busy0", {31'd0, req0_busy}, 32'd0);
    check("rst_busy1", {31'd0, req1_busy}, 32'd0);
    check("rst_addr", {16'd0, i2c_addr}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single port-0 write: exec visible 2 cycles after the strobe cycle
    issue(1'b0, 1'b0, 16'h0010, 8'hA5, 1'b1);
    check("t1_busy", {31'd0, req0_busy}, 32'd1);
    check("t1_exec_c1", {31'd0, i2c_exec}, 32'd0);
    tick();
    check("t1_exec_c2", {31'd0, i2c_exec}, 32'd1);
    check("t1_addr", {16'd0, i2c_addr}, 32'h0010);
    check("t1_dataw", {24'd0, i2c_data_w}, 32'hA5);
    check("t1_rhwl", {31'd0, i2c_rh_wl}, 32'd0);
    check("t1_bitctrl", {31'd0, bit_ctrl}, 32'd1);
    tick();
    check("t1_exec_c3", {31'd0, i2c_exec}, 32'd0);
    dri_done(1'b0, 8'hEE);
    check("t1_done", {31'd0, req0_done}, 32'd1);
    check("t1_ack", {31'd0, req0_ack}, 32'd0);
    check("t1_timeout", {31'd0, req0_timeout}, 32'd0);
    check("t1_busy_clr", {31'd0, req0_busy}, 32'd0);
    check("t1_p1_done", {31'd0, req1_done}, 32'd0);
    check("t1_p1_datar", {24'd0, req1_data_r}, 32'd0);
    tick();
    check("t1_done_pulse", {31'd0, req0_done}, 32'd0);

    // Simultaneous execs from a fresh reset: port 0 first, then port 1
    do_reset();
    base = exec_total;
    req1_rh_wl = 1'b1; req1_addr = 16'h0020; req1_data_w = 8'h00; req1_bit_ctrl = 1'b1;
    req1_exec = 1'b1;
    issue(1'b0, 1'b0, 16'h0030, 8'h5A, 1'b0);
    check("t2_busy1", {31'd0, req1_busy}, 32'd1);
    tick();
    check("t2_first_exec", {31'd0, i2c_exec}, 32'd1);
    check("t2_first_addr", {16'd0, i2c_addr}, 32'h0030);
    tick(); tick(); tick();
    check("t2_no_exec_wait", {31'd0, i2c_exec}, 32'd0);
    dri_done(1'b0, 8'h99);
    check("t2_done0", {31'd0, req0_done}, 32'd1);
    tick();
    check("t2_second_exec", {31'd0, i2c_exec}, 32'd1);
    check("t2_second_addr", {16'd0, i2c_addr}, 32'h0020);
    check("t2_second_rhwl", {31'd0, i2c_rh_wl}, 32'd1);
    tick();
    dri_done(1'b0, 8'h3C);
    check("t2_done1", {31'd0, req1_done}, 32'd1);
    check("t2_datar1", {24'd0, req1_data_r}, 32'h3C);
    check("t2_datar0_write", {24'd0, req0_data_r}, 32'd0);
    check("t2_exec_count", exec_total - base, 32'd2);

    // Port 0 re-execs on each done while port 1 waits: order p0,p1,p0,p0
    issue(1'b0, 1'b0, 16'h0100, 8'h01, 1'b1);
    wait_exec(16'h0100, "t3_a");
    issue(1'b1, 1'b0, 16'h0200, 8'h02, 1'b1);
    tick();
    dri_done(1'b0, 8'h00);
    check("t3_done_a", {31'd0, req0_done}, 32'd1);
    issue(1'b0, 1'b0, 16'h0101, 8'h03, 1'b1);
    wait_exec(16'h0200, "t3_b");
    tick();
    dri_done(1'b0, 8'h00);
    check("t3_done_b", {31'd0, req1_done}, 32'd1);
    wait_exec(16'h0101, "t3_c");
    tick();
    dri_done(1'b0, 8'h00);
    check("t3_done_c", {31'd0, req0_done}, 32'd1);
    issue(1'b0, 1'b0, 16'h0102, 8'h04, 1'b1);
    wait_exec(16'h0102, "t3_d");
    tick();
    dri_done(1'b1, 8'h00);
    check("t3_done_d", {31'd0, req0_done}, 32'd1);
    check("t3_nack_d", {31'd0, req0_ack}, 32'd1);

    // Hung transfer: watchdog completes after 64 WAIT cycles, then 64 DRAIN cycles
    issue(1'b0, 1'b0, 16'h0400, 8'h44, 1'b1);
    wait_exec(16'h0400, "t4_a");
    issue(1'b1, 1'b0, 16'h0440, 8'h45, 1'b0);
    flag = (req0_done !== 1'b0);
    for (int k = 0; k < 63; k++) begin
      tick();
      if (req0_done !== 1'b0) flag = 1'b1;
    end
    check("t4_no_early_done", {31'd0, flag}, 32'd0);
    tick();
    check("t4_to_done", {31'd0, req0_done}, 32'd1);
    check("t4_to_ack", {31'd0, req0_ack}, 32'd1);
    check("t4_to_flag", {31'd0, req0_timeout}, 32'd1);
    check("t4_busy0_clr", {31'd0, req0_busy}, 32'd0);
    check("t4_busy1_held", {31'd0, req1_busy}, 32'd1);
    flag = (i2c_exec !== 1'b0);
    for (int k = 0; k < 64; k++) begin
      tick();
      if (i2c_exec !== 1'b0) flag = 1'b1;
    end
    check("t4_no_exec_drain", {31'd0, flag}, 32'd0);
    tick();
    check("t4_exec_after_drain", {31'd0, i2c_exec}, 32'd1);
    check("t4_addr_after_drain", {16'd0, i2c_addr}, 32'h0440);
    tick();
    dri_done(1'b0, 8'h00);
    check("t4_done1", {31'd0, req1_done}, 32'd1);
    check("t4_timeout1", {31'd0, req1_timeout}, 32'd0);
    check("t4_timeout0_held", {31'd0, req0_timeout}, 32'd1);

    // Exec while busy is ignored
    base = exec_total;
    issue(1'b1, 1'b1, 16'h0500, 8'h00, 1'b1);
    wait_exec(16'h0500, "t5_a");
    tick(); tick(); tick();
    check("t5_busy_at_reexec", {31'd0, req1_busy}, 32'd1);
    issue(1'b1, 1'b0, 16'h0666, 8'h66, 1'b0);
    tick();
    dri_done(1'b0, 8'h77);
    check("t5_done1", {31'd0, req1_done}, 32'd1);
    check("t5_datar1", {24'd0, req1_data_r}, 32'h77);
    for (int k = 0; k < 10; k++) tick();
    check("t5_exec_count", exec_total - base, 32'd1);
    check("t5_busy_clr", {31'd0, req1_busy}, 32'd0);

    // Asynchronous reset in the middle of WAIT
    issue(1'b0, 1'b1, 16'h0600, 8'h00, 1'b1);
    wait_exec(16'h0600, "t6_a");
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy0", {31'd0, req0_busy}, 32'd0);
    check("t6_addr", {16'd0, i2c_addr}, 32'd0);
    check("t6_rhwl", {31'd0, i2c_rh_wl}, 32'd0);
    check("t6_datar1", {24'd0, req1_data_r}, 32'd0);
    check("t6_ack0", {31'd0, req0_ack}, 32'd0);
    check("t6_timeout0", {31'd0, req0_timeout}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (req0_done !== 1'b0 || i2c_exec !== 1'b0) flag = 1'b1;
    end
    check("t6_no_done_after_rst", {31'd0, flag}, 32'd0);
    issue(1'b0, 1'b0, 16'h0700, 8'h70, 1'b0);
    wait_exec(16'h0700, "t6_b");
    tick();
    dri_done(1'b0, 8'h00);
    check("t6_done0", {31'd0, req0_done}, 32'd1);
    check("t6_ack0_post", {31'd0, req0_ack}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
